layer_mem_arbiter: RTL and testbench

//  Shares the single layer-memory port (cwr/crd/csel/caddr/cdata) between two requesters.

---
 rtl/layer_mem_arbiter_if.sv | 40 ++++
 rtl/layer_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_layer_mem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/layer_mem_arbiter_if.sv
// Bundle for the shared layer-memory port: two requester channels on one side,
// the single memory port on the other.
interface layer_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  // rq_req[i] is a level request and the requester holds we/sel/addr/wdata until
  // rq_gnt[i] rises; the access completes in the grant cycle (no separate ready).
  logic [1:0]    rq_req;
  logic [1:0]    rq_lock;
  logic [1:0]    rq_we;
  logic [2:0]    rq_sel0;
  logic [2:0]    rq_sel1;
  logic [AW-1:0] rq_addr0;
  logic [AW-1:0] rq_addr1;
  logic [DW-1:0] rq_wdata0;
  logic [DW-1:0] rq_wdata1;
  logic [1:0]    rq_gnt;
  logic [DW-1:0] rq_rdata;
  logic [1:0]    rq_rvalid;
  logic          cwr;
  logic          crd;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;

  modport slave (
    input  rq_req, rq_lock, rq_we, rq_sel0, rq_sel1, rq_addr0, rq_addr1,
           rq_wdata0, rq_wdata1, cdata_rd,
    output rq_gnt, rq_rdata, rq_rvalid, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd
  );

  modport master (
    output rq_req, rq_lock, rq_we, rq_sel0, rq_sel1, rq_addr0, rq_addr1,
           rq_wdata0, rq_wdata1, cdata_rd,
    input  rq_gnt, rq_rdata, rq_rvalid, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd
  );
endinterface

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter with burst lock for the shared layer-memory port.
// Grants are combinational from registered state and live requests.
module layer_mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 20,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  layer_mem_arbiter_if.slave bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;
  logic       arb_win;
  logic       arb_grant;
  logic       owner;
  logic       other;
  logic       g_idx;
  logic       g_any;
  logic       g_we;
  logic [2:0]    g_sel;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  always_comb begin
    gnt_raw   = 2'b00;
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    arb_grant = 1'b0;
    arb_win   = (bus.rq_req == 2'b11) ? rr_q : bus.rq_req[1];
    owner     = (state_q == ST_LOCK1);
    other     = ~owner;

    case (state_q)
      ST_LOCK0, ST_LOCK1: begin
        // >= keeps the waiter's bound even if the counter ran past the cap while it was idle
        if ((cnt_q >= MAX_B) && bus.rq_req[other]) begin
          gnt_raw[other] = 1'b1;
          rr_d           = owner;
          if (bus.rq_lock[other]) begin
            state_d = other ? ST_LOCK1 : ST_LOCK0;
            cnt_d   = 4'd1;
          end else begin
            state_d = ST_ARB;
            cnt_d   = 4'd0;
          end
        end else if (bus.rq_req[owner]) begin
          gnt_raw[owner] = 1'b1;
          cnt_d          = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          if (!bus.rq_lock[owner]) begin
            state_d = ST_ARB;
            rr_d    = other;
          end
        end else begin
          arb_grant = 1'b1;
        end
      end
      default: arb_grant = 1'b1;
    endcase

    if (arb_grant) begin
      state_d = ST_ARB;
      cnt_d   = 4'd0;
      if (|bus.rq_req) begin
        gnt_raw[arb_win] = 1'b1;
        rr_d             = ~arb_win;
        if (bus.rq_lock[arb_win]) begin
          state_d = arb_win ? ST_LOCK1 : ST_LOCK0;
          cnt_d   = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARB;
      rr_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset is applied combinationally so no access leaks out while it is held.
  assign gnt     = gnt_raw & {2{reset}};
  assign g_any   = |gnt;
  assign g_idx   = gnt[1];
  assign g_we    = bus.rq_we[g_idx];
  assign g_sel   = g_idx ? bus.rq_sel1   : bus.rq_sel0;
  assign g_addr  = g_idx ? bus.rq_addr1  : bus.rq_addr0;
  assign g_wdata = g_idx ? bus.rq_wdata1 : bus.rq_wdata0;

  assign bus.rq_gnt    = gnt;
  assign bus.rq_rvalid = gnt & ~bus.rq_we;
  assign bus.rq_rdata  = reset ? bus.cdata_rd : '0;
  assign bus.cwr       = g_any & g_we;
  assign bus.crd       = g_any & ~g_we;
  assign bus.csel      = g_any ? g_sel : 3'b000;
  assign bus.caddr_wr  = (g_any &  g_we) ? g_addr  : '0;
  assign bus.cdata_wr  = (g_any &  g_we) ? g_wdata : '0;
  assign bus.caddr_rd  = (g_any & ~g_we) ? g_addr  : '0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: driver pushes the expected port image
// for each cycle, a negedge monitor pops and compares.
module tb_layer_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 20;
  localparam int W  = 2 + 2 + 2 + 1 + 1 + 3 + AW + DW + AW + DW;
  localparam logic [1:0] S_ARB = 2'd0;
  localparam logic [1:0] S_L0  = 2'd1;
  localparam logic [1:0] S_L1  = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  layer_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  layer_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int vec_no;

  logic          rst_v;
  logic [2:0]    s0, s1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1, cd;

  // driver: apply one cycle of stimulus and push the expected outputs
  task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                      input logic [1:0] egnt, input logic [1:0] est);
    logic          idx;
    logic          e_cwr, e_crd;
    logic [2:0]    e_sel;
    logic [AW-1:0] e_awr, e_ard;
    logic [DW-1:0] e_dwr, e_rd;
    @(posedge clk);
    #1;
    reset         = rst_v;
    bus.rq_req    = req;
    bus.rq_lock   = lock;
    bus.rq_we     = we;
    bus.rq_sel0   = s0;
    bus.rq_sel1   = s1;
    bus.rq_addr0  = a0;
    bus.rq_addr1  = a1;
    bus.rq_wdata0 = d0;
    bus.rq_wdata1 = d1;
    bus.cdata_rd  = cd;
    idx   = egnt[1];
    e_cwr = 1'b0; e_crd = 1'b0; e_sel = 3'b000;
    e_awr = '0;   e_ard = '0;   e_dwr = '0;
    if (egnt != 2'b00) begin
      e_sel = idx ? s1 : s0;
      if (we[idx]) begin
        e_cwr = 1'b1;
        e_awr = idx ? a1 : a0;
        e_dwr = idx ? d1 : d0;
      end else begin
        e_crd = 1'b1;
        e_ard = idx ? a1 : a0;
      end
    end
    e_rd = rst_v ? cd : '0;
    exp_q.push_back({est, egnt, egnt & ~we, e_cwr, e_crd, e_sel, e_awr, e_dwr, e_ard, e_rd});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      act = {dbg_state, bus.rq_gnt, bus.rq_rvalid, bus.cwr, bus.crd, bus.csel,
             bus.caddr_wr, bus.cdata_wr, bus.caddr_rd, bus.rq_rdata};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec%0d st/gnt/rv/wr/rd/sel/awr/dwr/ard/rdata actual %h required %h",
                 vec_no, act, exp);
      end
      vec_no++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; vec_no = 0;
    reset = 1'b0; rst_v = 1'b0;
    s0 = 3'b000; s1 = 3'b001; a0 = 12'h010; a1 = 12'h020;
    d0 = 20'h0; d1 = 20'h0; cd = 20'h12345;
    bus.rq_req = 2'b00; bus.rq_lock = 2'b00; bus.rq_we = 2'b00;
    bus.rq_sel0 = '0; bus.rq_sel1 = '0; bus.rq_addr0 = '0; bus.rq_addr1 = '0;
    bus.rq_wdata0 = '0; bus.rq_wdata1 = '0; bus.cdata_rd = '0;

    // reset held with both requesting: nothing granted
    step(2'b11, 2'b00, 2'b00, 2'b00, S_ARB);
    step(2'b11, 2'b00, 2'b00, 2'b00, S_ARB);

    // release, round-robin with both requesting
    rst_v = 1'b1;
    for (int i = 0; i < 6; i++)
      step(2'b11, 2'b00, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, S_ARB);
    step(2'b00, 2'b00, 2'b00, 2'b00, S_ARB);

    // lock burst: requester 1 reads 0,1,64,65; requester 0 joins in cycle 2
    s0 = 3'b010; a0 = 12'h055;
    a1 = 12'd0;  step(2'b10, 2'b10, 2'b00, 2'b10, S_ARB);
    a1 = 12'd1;  step(2'b11, 2'b10, 2'b00, 2'b10, S_L1);
    a1 = 12'd64; step(2'b11, 2'b10, 2'b00, 2'b10, S_L1);
    a1 = 12'd65; step(2'b11, 2'b10, 2'b00, 2'b10, S_L1);
    step(2'b01, 2'b00, 2'b00, 2'b01, S_L1);
    step(2'b00, 2'b00, 2'b00, 2'b00, S_ARB);

    // starvation cap: requester 1 locks forever, requester 0 waits at most 4 grants
    a1 = 12'h200;
    step(2'b11, 2'b10, 2'b00, 2'b10, S_ARB);
    for (int i = 0; i < 3; i++)
      step(2'b11, 2'b10, 2'b00, 2'b10, S_L1);
    step(2'b11, 2'b10, 2'b00, 2'b01, S_L1);
    step(2'b11, 2'b10, 2'b00, 2'b10, S_ARB);
    step(2'b11, 2'b10, 2'b00, 2'b10, S_L1);
    step(2'b00, 2'b10, 2'b00, 2'b00, S_L1);
    step(2'b00, 2'b00, 2'b00, 2'b00, S_ARB);

    // owner idle while locked: the other requester wins through normal arbitration
    step(2'b01, 2'b01, 2'b00, 2'b01, S_ARB);
    step(2'b10, 2'b00, 2'b00, 2'b10, S_L0);

    // write and read paths
    s0 = 3'b001; a0 = 12'hFFF; d0 = 20'h01310;
    step(2'b01, 2'b00, 2'b01, 2'b01, S_ARB);
    cd = 20'hABCDE;
    step(2'b01, 2'b00, 2'b00, 2'b01, S_ARB);
    s1 = 3'b101; a1 = 12'h123; d1 = 20'hFFFFF;
    step(2'b10, 2'b00, 2'b10, 2'b10, S_ARB);
    step(2'b11, 2'b00, 2'b01, 2'b01, S_ARB);
    step(2'b11, 2'b00, 2'b01, 2'b10, S_ARB);

    // lock without request is ignored
    step(2'b01, 2'b10, 2'b00, 2'b01, S_ARB);
    step(2'b00, 2'b00, 2'b00, 2'b00, S_ARB);

    // reset in the 2nd cycle of a LOCK1 burst aborts it
    step(2'b10, 2'b10, 2'b00, 2'b10, S_ARB);
    rst_v = 1'b0;
    step(2'b10, 2'b10, 2'b00, 2'b00, S_ARB);
    rst_v = 1'b1;
    step(2'b11, 2'b00, 2'b00, 2'b01, S_ARB);
    step(2'b00, 2'b00, 2'b00, 2'b00, S_ARB);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
